// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits and 4-word line fills from a multi-cycle memory.
// Optional hit/miss statistics counters are enabled with the ICACHE_STATS_EN macro.
module icache_direct #(
    parameter int LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_readC,
    input  logic [15:0] i_address,
    output logic [15:0] i_data,
    output logic        i_ready,
    input  logic        flush_all,
    output logic        mem_read,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_data,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 14 - INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_FILL} state_t;

    state_t state, state_nx;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [63:0]        data_mem [LINES];
    logic               discard;

    logic [63:0]        fill_data_p0;
    logic [TAG_W-1:0]   fill_tag_p0;
    logic [INDEX_W-1:0] fill_idx_p0;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_off;
    logic               hit;
    logic               miss_start;

    function automatic logic [15:0] sel_word(input logic [63:0] line, input logic [1:0] off);
        logic [15:0] w;
        case (off)
            2'd0:    w = line[15:0];
            2'd1:    w = line[31:16];
            2'd2:    w = line[47:32];
            default: w = line[63:48];
        endcase
        return w;
    endfunction

    assign req_tag    = i_address[15 -: TAG_W];
    assign req_idx    = i_address[2 +: INDEX_W];
    assign req_off    = i_address[1:0];
    assign hit        = i_readC & valid[req_idx] & (tag_mem[req_idx] == req_tag);
    assign miss_start = (state == S_IDLE) & i_readC & ~hit & ~flush_all;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (miss_start) state_nx = S_MISS;
            // A flushed fill still has to wait for its ack before memory is free again.
            S_MISS: if (mem_ack) state_nx = (discard | flush_all) ? S_IDLE : S_FILL;
            S_FILL: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        i_ready  = 1'b0;
        i_data   = 16'd0;
        mem_read = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit & ~flush_all) begin
                    i_ready = 1'b1;
                    i_data  = sel_word(data_mem[req_idx], req_off);
                end
            end
            S_MISS:  mem_read = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= '0;
            discard     <= 1'b0;
            mem_address <= 16'd0;
        end else begin
            if (miss_start) begin
                mem_address <= {i_address[15:2], 2'b00};
                discard     <= 1'b0;
            end
            if (state == S_MISS && flush_all) discard <= 1'b1;
            if (flush_all)
                valid <= '0;
            else if (state == S_FILL)
                valid[fill_idx_p0] <= 1'b1;
        end
    end

    // Stage p0: capture returned line at ack; stage p1: write arrays in FILL
    always_ff @(posedge clk) begin
        if (state == S_MISS && mem_ack) begin
            fill_data_p0 <= mem_data;
            fill_tag_p0  <= mem_address[15 -: TAG_W];
            fill_idx_p0  <= mem_address[2 +: INDEX_W];
        end
        if (state == S_FILL) begin
            data_mem[fill_idx_p0] <= fill_data_p0;
            tag_mem[fill_idx_p0]  <= fill_tag_p0;
        end
    end

`ifdef ICACHE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (i_readC & i_ready) hit_count  <= sat_inc(hit_count);
            if (miss_start)        miss_count <= sat_inc(miss_count);
        end
    end
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: fetch expectations are queued when driven and popped when i_ready is seen.
module tb_icache_direct;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_readC;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        flush_all;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    int          req_cnt = 0;
    logic [15:0] last_req = 16'd0;
    logic [15:0] first_addr = 16'd0;
    bit          stray_req = 1'b0;

    icache_direct #(.LINES(4)) dut (
        .clk(clk), .reset(reset), .i_readC(i_readC), .i_address(i_address),
        .i_data(i_data), .i_ready(i_ready), .flush_all(flush_all),
        .mem_read(mem_read), .mem_address(mem_address), .mem_data(mem_data),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1111 * ({14'd0, a[1:0]} + 16'd1) + ((a & 16'hFFFC) << 4);
    endfunction

    function automatic logic [63:0] line_of(input logic [15:0] base);
        return {mem_word(base | 16'd3), mem_word(base | 16'd2),
                mem_word(base | 16'd1), mem_word(base)};
    endfunction

    // Memory model: acks LAT cycles after mem_read rises, or a stray ack on request.
    initial begin
        int lat;
        lat = 0;
        mem_ack = 1'b0;
        mem_data = 64'd0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (stray_req) begin
                mem_ack = 1'b1;
                mem_data = 64'hDEAD_BEEF_CAFE_F00D;
                stray_req = 1'b0;
            end else if (mem_read) begin
                if (lat == 0) first_addr = mem_address;
                lat++;
                if (lat == LAT) begin
                    check_eq("mem_addr_stable", mem_address, first_addr);
                    check_eq("mem_addr_align", {62'd0, mem_address[1:0]}, 64'd0);
                    mem_ack = 1'b1;
                    mem_data = line_of(mem_address);
                    last_req = mem_address;
                    req_cnt++;
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            if (i_readC && i_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_ready", 64'd1, 64'd0);
                else check_eq("i_data", i_data, exp_q.pop_front());
            end
        end
    end

    task automatic fetch(input logic [15:0] a, input bit exp_hit, input string tag);
        int waits;
        int req0;
        waits = 0;
        req0 = req_cnt;
        i_address = a;
        i_readC = 1'b1;
        exp_q.push_back(mem_word(a));
        forever begin
            @(negedge clk);
            if (i_ready) break;
            if (waits == 1) begin
                check_eq({tag, "_mem_read"}, mem_read, 1);
                check_eq({tag, "_mem_addr"}, mem_address, {a[15:2], 2'b00});
            end
            waits++;
            if (waits > 60) begin
                check_eq({tag, "_timeout"}, 1, 0);
                break;
            end
        end
        if (exp_hit) begin
            check_eq({tag, "_hit_lat"}, waits, 0);
            check_eq({tag, "_no_mem_read"}, mem_read, 0);
            check_eq({tag, "_req_cnt"}, req_cnt, req0);
        end else begin
            check_eq({tag, "_miss_lat"}, waits, LAT + 2);
            check_eq({tag, "_req_cnt"}, req_cnt, req0 + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_mem_read(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read && n < 20);
        check_eq({tag, "_mem_read_seen"}, mem_read, 1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 60);
        check_eq({tag, "_ready_seen"}, i_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string tag, input int hits, input int misses);
`ifdef ICACHE_STATS_EN
        check_eq({tag, "_hit_count"}, hit_count, hits);
        check_eq({tag, "_miss_count"}, miss_count, misses);
`else
        check_eq({tag, "_hit_count"}, hit_count, 0 * hits);
        check_eq({tag, "_miss_count"}, miss_count, 0 * misses);
`endif
    endtask

    initial begin
        int req0;
        reset = 1'b1;
        i_readC = 1'b0;
        i_address = 16'd0;
        flush_all = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_i_ready", i_ready, 0);
        check_eq("rst_i_data", i_data, 0);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_address", mem_address, 0);
        check_stats("rst", 0, 0);
        @(posedge clk); #1;

        // First miss then three hits on the same line
        fetch(16'h0005, 1'b0, "miss5");
        check_stats("after_miss", 1, 1);
        fetch(16'h0004, 1'b1, "hit4");
        fetch(16'h0006, 1'b1, "hit6");
        fetch(16'h0007, 1'b1, "hit7");
        check_stats("after_hits", 4, 1);

        // No request: no ready, no miss
        i_readC = 1'b0;
        i_address = 16'h0100;
        @(negedge clk);
        check_eq("idle_ready", i_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("idle_mem_read", mem_read, 0);
        @(posedge clk); #1;

        // Conflict on index 0
        fetch(16'h0010, 1'b0, "conf10");
        fetch(16'h0000, 1'b0, "conf00");
        fetch(16'h0003, 1'b1, "hit03");

        // Redirect during MISS
        req0 = req_cnt;
        i_address = 16'h0008;
        i_readC = 1'b1;
        wait_mem_read("redir");
        @(posedge clk); #1;
        i_address = 16'h0020;
        exp_q.push_back(mem_word(16'h0020));
        wait_ready("redir");
        check_eq("redir_req_cnt", req_cnt, req0 + 2);
        check_eq("redir_last_req", last_req, 16'h0020);
        fetch(16'h0009, 1'b1, "hit09");

        // Flush in IDLE on a hitting address
        i_address = 16'h0009;
        flush_all = 1'b1;
        @(negedge clk);
        check_eq("flush_idle_ready", i_ready, 0);
        @(posedge clk); #1;
        flush_all = 1'b0;
        fetch(16'h0009, 1'b0, "post_flush");

        // Flush during MISS: fill discarded, refetch misses again
        req0 = req_cnt;
        i_address = 16'h0041;
        exp_q.push_back(mem_word(16'h0041));
        wait_mem_read("flmiss");
        @(posedge clk); #1;
        flush_all = 1'b1;
        @(posedge clk); #1;
        flush_all = 1'b0;
        wait_ready("flmiss");
        check_eq("flmiss_req_cnt", req_cnt, req0 + 2);
        check_eq("flmiss_last_req", last_req, 16'h0040);

        // Reset mid-miss, then a stray ack
        i_address = 16'h0082;
        exp_q.push_back(mem_word(16'h0082));
        wait_mem_read("rstmiss");
        @(posedge clk); #1;
        reset = 1'b1;
        i_readC = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("rstmiss_mem_read", mem_read, 0);
        check_stats("rstmiss", 0, 0);
        @(posedge clk); #1;
        stray_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("stray_mem_read", mem_read, 0);
        check_eq("stray_ready", i_ready, 0);
        @(posedge clk); #1;
        fetch(16'h0082, 1'b0, "after_rst82");
        fetch(16'h0005, 1'b0, "after_rst05");
        fetch(16'h0083, 1'b1, "hit83");
        i_readC = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
